binar_thresh_ctrl: RTL
======================

# binar_thresh_ctrl

Frame-level threshold controller for the binarization stage. It monitors the luminance stream that feeds the binarizer and accumulates the sum and count of active pixels per frame. At frame end it computes the mean with a multi-cycle divider, then applies an offset and clamp. The resulting threshold is committed at the start of the next frame, so the binarizer threshold never changes mid-frame; a manual override mode is also provided.

## Interface
Parameters:
- CNT_W, 21, pixel-counter width; 21 covers 1920x1080.
- INIT_TH, 128, threshold value after reset.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- vsync_in  in  1  frame sync, active-high; a rising edge marks frame end.
- de_in  in  1  active-pixel enable.
- y_in  in  8  luminance, sampled when de_in=1.
- cfg_mode  in  1  0 = manual, 1 = auto (mean-based).
- cfg_manual_th  in  8  threshold used in manual mode.
- cfg_offset  in  8  signed two's-complement offset added to the mean.
- cfg_th_min  in  8  lower clamp bound.
- cfg_th_max  in  8  upper clamp bound.
- threshold  out  8  committed threshold to the binarizer; frame-stable.
- mean_out  out  8  last computed frame mean.
- busy  out  1  high during DIV and APPLY.
- frame_done  out  1  one-cycle pulse when a new pending threshold is ready.

## Operation
- Edge detect: vsync_d is a registered copy of vsync_in. rise = vsync_in & ~vsync_d. fall = ~vsync_in & vsync_d.
- Accumulation:
  - When de_in=1, vsync_in=0 and cnt is not all-ones: sum += y_in and cnt += 1.
  - sum is CNT_W+8 bits.
  - Once cnt saturates at all-ones, further pixels are ignored; the mean is taken over the counted pixels.
- States:
  - ACC: the reset state. On rise, latch sum and cnt into divider registers, clear the accumulators, and go to DIV.
    - If the latched cnt is 0, skip to IDLE_WAIT with no update and no frame_done.
  - DIV: 8 iterations of restoring division, MSB first, quotient bit k = 7..0.
    - Each iteration: if rem >= (cnt<<k), then rem -= cnt<<k and q[k] = 1.
    - The quotient is exact floor(sum/cnt) because sum < 256*cnt.
  - APPLY: one cycle.
    - t = q + sign-extended cfg_offset, computed as 10-bit signed.
    - Saturate t to 0..255, then clamp up to cfg_th_min, then clamp down to cfg_th_max. The max is applied last, so min>max yields cfg_th_max.
    - pending <= result, mean_out <= q, frame_done = 1. Then return to ACC.
  - IDLE_WAIT: a synonym for ACC, entered when cnt was 0. Accumulation continues normally.
- Accumulation for the next frame continues in all states; DIV and APPLY use only the latched registers.
- Manual mode: pending <= cfg_manual_th every cycle while cfg_mode=0. The divider still runs and mean_out still updates.
- Commit rules:
  - On fall: threshold <= pending, unless busy=1.
  - If fall occurs while busy, the commit is deferred to the APPLY cycle, using the new result.
- A rise while busy: that frame's stats are discarded, the accumulators are cleared, and the running division completes unaffected.
- Reset (including mid-DIV): state ACC, accumulators 0, threshold = INIT_TH, pending = INIT_TH, mean_out 0, busy 0, frame_done 0.

## Timing
- rise sampled at edge t:
  - DIV occupies cycles t+1..t+8.
  - APPLY occurs at t+9.
  - frame_done, mean_out and pending are visible after edge t+9.
- busy is high from t+1 through t+9 inclusive.
- Commit latency: threshold updates on the edge that samples fall and is visible the next cycle.
- threshold changes only on a fall commit or a deferred APPLY commit, never during de_in=1 of an active frame.
- No combinational paths from inputs to outputs.

## Test plan
- Auto mode, offset 0, min 0, max 255; frame of 16 pixels all y=100; vsync high for 20 cycles. Required: busy for 9 cycles, frame_done at t+9, mean_out=100, threshold=100 after fall.
- 8 pixels y=0 and 8 pixels y=255. Required: mean_out=127 (floor), threshold=127.
- Mean 100, offset -128. Required: threshold=0 (saturated). Same mean with cfg_th_min=40: threshold=40. Mean 200, offset +100, cfg_th_max=220: threshold=220. cfg_th_min=200 with cfg_th_max=150: threshold=150.
- Frame with no de_in pulses. Required: no frame_done, and threshold keeps its prior value through the fall.
- Manual mode, cfg_manual_th=77, mid-frame change to 90. Required: threshold stays at the old value until fall, then becomes 90. mean_out still updates.
- Edge cases:
  - vsync pulse of 3 cycles: the fall occurs while busy, and the commit happens at APPLY (t+9).
  - Assert rst_n=0 at t+4 mid-DIV: all outputs return to reset values immediately, and threshold=128.

Source files
------------

// File: rtl/binar_thresh_ctrl.sv
// Frame-level threshold controller for the binarizer.
// Accumulates luminance sum/count per frame. At frame end it divides for the
// mean, applies a signed offset plus min/max clamp, and commits the result at
// the next frame start, so the binarizer threshold is stable within a frame.
//
// Handshake: there is no valid/ready pair. Pixels are accepted on any clock
// with de_in=1 and vsync_in=0. frame_done is a single-cycle strobe with no
// backpressure. threshold changes only on a vsync falling-edge commit, or on
// the APPLY cycle when that falling edge arrived while busy.
module binar_thresh_ctrl #(
  parameter int CNT_W   = 21,
  parameter int INIT_TH = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic [7:0] y_in,
  input  logic       cfg_mode,
  input  logic [7:0] cfg_manual_th,
  input  logic [7:0] cfg_offset,
  input  logic [7:0] cfg_th_min,
  input  logic [7:0] cfg_th_max,
  output logic [7:0] threshold,
  output logic [7:0] mean_out,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ACC       = 2'd0,
    DIV       = 2'd1,
    APPLY     = 2'd2,
    IDLE_WAIT = 2'd3
  } state_t;

  localparam int SUM_W = CNT_W + 8;

  state_t             state;
  logic               vsync_d;
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   rem;
  logic [CNT_W-1:0]   dvs;
  logic [7:0]         q;
  logic [2:0]         k;
  logic               defer;
  logic [7:0]         pending;

  logic               rise;
  logic               fall;
  logic               acc_en;
  logic [SUM_W-1:0]   div_sh;
  logic signed [9:0]  t_s;
  logic [7:0]         sat_v;
  logic [7:0]         clamp_v;
  logic [7:0]         pend_new;

  assign rise      = vsync_in & ~vsync_d;
  assign fall      = ~vsync_in & vsync_d;
  assign acc_en    = de_in & ~vsync_in & ~(&cnt);
  assign div_sh    = {8'd0, dvs} << k;
  assign state_dbg = state;

  // Offset, saturate to 0..255, then min clamp followed by max clamp (max wins).
  always_comb begin
    t_s     = $signed({2'b00, q}) + $signed({{2{cfg_offset[7]}}, cfg_offset});
    sat_v   = t_s[7:0];
    if (t_s[9])      sat_v = 8'd0;
    else if (t_s[8]) sat_v = 8'd255;
    clamp_v = sat_v;
    if (clamp_v < cfg_th_min) clamp_v = cfg_th_min;
    if (clamp_v > cfg_th_max) clamp_v = cfg_th_max;
    pend_new = cfg_mode ? clamp_v : cfg_manual_th;
  end

  // Running frame statistics; any frame start clears them (latched or discarded).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      sum     <= '0;
      cnt     <= '0;
    end else begin
      vsync_d <= vsync_in;
      if (rise) begin
        sum <= '0;
        cnt <= '0;
      end else if (acc_en) begin
        sum <= sum + {{CNT_W{1'b0}}, y_in};
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Control FSM: latch stats, restoring divide, apply/commit threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      rem        <= '0;
      dvs        <= '0;
      q          <= '0;
      k          <= '0;
      defer      <= 1'b0;
      pending    <= 8'(INIT_TH);
      threshold  <= 8'(INIT_TH);
      mean_out   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!cfg_mode) pending <= cfg_manual_th;
      // Commit on frame start unless a result is in flight; then defer to APPLY.
      if (fall && !busy) threshold <= pending;
      if (fall && busy && state != APPLY) defer <= 1'b1;
      case (state)
        ACC, IDLE_WAIT: begin
          if (rise) begin
            if (cnt == '0) begin
              state <= IDLE_WAIT;
            end else begin
              rem   <= sum;
              dvs   <= cnt;
              q     <= '0;
              k     <= 3'd7;
              busy  <= 1'b1;
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (rem >= div_sh) begin
            rem  <= rem - div_sh;
            q[k] <= 1'b1;
          end
          if (k == 3'd0) state <= APPLY;
          else           k     <= k - 3'd1;
        end
        APPLY: begin
          pending    <= pend_new;
          mean_out   <= q;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= ACC;
          if (defer || fall) threshold <= pend_new;
          defer      <= 1'b0;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
